// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU constants and fetch-entry layout for the instruction fetch unit.
// The IFU_PERF_CNT_EN macro (see instruction_fetch_unit.sv) enables fetch/redirect counters.
package instruction_fetch_unit_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;
   localparam int ENTRY_W     = 2 * XLEN;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   localparam fetch_entry_t RESET_ENTRY = '{pc: '0, instr: NOP_INSTR};

   // Clears the byte-offset bits so a redirect always lands on an instruction boundary.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(INSTR_BYTES - 1);
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Registered FIFO of fetched {pc, instr} entries with push, pop and whole-queue flush.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_queue #(
   parameter int               DEPTH      = 2,
   parameter int               WIDTH      = 64,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign head_valid = (count != '0);
   assign full       = (count == CNT_W'(DEPTH));
   assign head_data  = mem[rd_ptr];

   // A push into a full queue is only legal when the head leaves in the same cycle.
   assign do_pop  = pop && head_valid;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RESET_DATA;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC sequencing, redirect handling and a registered fetch queue toward decode.
// Define IFU_PERF_CNT_EN to add saturating FETCH_COUNT / REDIRECT_COUNT outputs.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic [31:0] IMEM_PC,
   input  logic [31:0] IMEM_INSTR,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OUT_PC,
   output logic [31:0] OUT_INSTR
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] FETCH_COUNT,
   output logic [31:0] REDIRECT_COUNT
`endif
);

   logic [XLEN-1:0] pc_q;
   logic            q_full;
   logic            q_valid;
   logic            pop;
   logic            push;
   logic [ENTRY_W-1:0] head_bits;
   fetch_entry_t    head;
   fetch_entry_t    new_entry;

   assign IMEM_PC = pc_q;

   // Redirect wins over both ends of the queue in the same cycle.
   assign pop  = q_valid && OUT_READY && !REDIRECT;
   assign push = !REDIRECT && (!q_full || pop);

   assign new_entry = '{pc: pc_q, instr: IMEM_INSTR};

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pc_q <= RESET_PC;
      end else if (REDIRECT) begin
         pc_q <= align_word(REDIRECT_PC);
      end else if (push) begin
         pc_q <= pc_q + XLEN'(INSTR_BYTES);
      end
   end

   fetch_queue #(
      .DEPTH      (QUEUE_DEPTH),
      .WIDTH      (ENTRY_W),
      .RESET_DATA (RESET_ENTRY)
   ) u_fetch_queue (
      .clk        (CLK),
      .rst_n      (RESET),
      .push       (push),
      .push_data  (new_entry),
      .pop        (pop),
      .flush      (REDIRECT),
      .head_data  (head_bits),
      .head_valid (q_valid),
      .full       (q_full)
   );

   assign head      = fetch_entry_t'(head_bits);
   assign OUT_VALID = q_valid;
   assign OUT_PC    = head.pc;
   assign OUT_INSTR = head.instr;

`ifdef IFU_PERF_CNT_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         FETCH_COUNT    <= '0;
         REDIRECT_COUNT <= '0;
      end else begin
         if (push && (FETCH_COUNT != '1)) begin
            FETCH_COUNT <= FETCH_COUNT + 32'd1;
         end
         if (REDIRECT && (REDIRECT_COUNT != '1)) begin
            REDIRECT_COUNT <= REDIRECT_COUNT + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2: fetch queue entries; power of two, >=2.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IMEM_PC  output  32  fetch address to instruction memory (byte address, word aligned).
REQ-006 SHALL have port IMEM_INSTR  input  32  instruction word returned for IMEM_PC within the same cycle.
REQ-007 SHALL have port REDIRECT  input  1  branch/jump taken; flush and refetch.
REQ-008 SHALL have port REDIRECT_PC  input  32  redirect target.
REQ-009 SHALL have port OUT_VALID  output  1  head entry valid toward decode.
REQ-010 SHALL have port OUT_READY  input  1  decode accepts head entry.
REQ-011 SHALL have port OUT_PC  output  32  PC of head entry.
REQ-012 SHALL have port OUT_INSTR  output  32  instruction of head entry.

Function
REQ-013 SHALL hold PC register; IMEM_PC = PC at all times.
REQ-014 SHALL push {PC, IMEM_INSTR} and advance PC by 4 in any cycle with REDIRECT=0 and (count < QUEUE_DEPTH or a pop occurs that cycle).
REQ-015 SHALL hold PC and not push while queue full with no pop (stall).
REQ-016 SHALL pop head when OUT_VALID=1 and OUT_READY=1; OUT_VALID = (count != 0).
REQ-017 SHALL keep OUT_PC/OUT_INSTR stable while OUT_VALID=1 and OUT_READY=0.
REQ-018 SHALL, on REDIRECT=1, empty the queue, load PC <= {REDIRECT_PC[31:2], 2'b00}, push nothing; REDIRECT overrides a same-cycle pop and push.
REQ-019 SHALL wrap PC modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-020 SHALL deliver first entry with OUT_VALID=1 one cycle after reset release (queue is registered; no combinational IMEM_INSTR-to-OUT path).
REQ-021 SHALL sustain one instruction per cycle when OUT_READY held high.
REQ-022 SHALL wrap queue read/write pointers modulo QUEUE_DEPTH; simultaneous push and pop leaves count unchanged.

Reset
REQ-023 SHALL on RESET=0 immediately set PC=RESET_PC, count=0, pointers=0, OUT_VALID=0, OUT_PC=0, OUT_INSTR=32'h0000_0013 (NOP).
REQ-024 SHALL discard all queued entries when reset asserts mid-operation; fetching resumes at RESET_PC on first edge after release.

Configuration
REQ-025 SHALL, with IFU_PERF_CNT_EN defined, add outputs FETCH_COUNT (32, pushes) and REDIRECT_COUNT (32, redirects), both saturating at 32'hFFFF_FFFF and cleared by reset.
REQ-026 SHALL, without IFU_PERF_CNT_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-027 SHALL place XLEN=32, INSTR_BYTES=4 and NOP encoding 32'h0000_0013 in the shared CPU constants package.
REQ-028 SHALL implement the queue as sub-module fetch_queue (push/pop/flush, data width 64, depth QUEUE_DEPTH); PC logic stays in top.

Verification
REQ-029 SHALL cover: reset release, OUT_READY=1, IMEM returns PC-indexed words -> OUT_PC 0,4,8,12 on consecutive cycles from cycle 1.
REQ-030 SHALL cover: OUT_READY=0 for 5 cycles -> two entries queued (PC 0,4), IMEM_PC holds 8, OUT_PC stays 0; OUT_READY=1 -> 0,4,8 in order.
REQ-031 SHALL cover: REDIRECT=1, REDIRECT_PC=32'h0000_0103 with queue full and OUT_READY=1 -> next cycle OUT_VALID=0, IMEM_PC=32'h100; following cycle OUT_PC=32'h100.
REQ-032 SHALL cover: REDIRECT_PC=32'hFFFF_FFF8 -> OUT_PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-033 SHALL cover: RESET asserted asynchronously between edges with queue non-empty -> OUT_VALID=0 and IMEM_PC=RESET_PC before the next edge.
REQ-034 SHALL cover (IFU_PERF_CNT_EN): 10 accepted fetches plus 1 redirect -> FETCH_COUNT=10, REDIRECT_COUNT=1.
